// File: rtl/vq_buf_pkg.sv
// Shared sizing helpers for the VQ ping-pong bank buffer.
// Bank pointer width and per-bank length width derive from the parameters.
package vq_buf_pkg;

    localparam int MAX_BANKS = 4;

    function automatic int bank_w(input int num_banks);
        return (num_banks <= 2) ? 1 : $clog2(MAX_BANKS);
    endfunction

    // A bank may hold exactly 2**addr_width words, so the count needs one extra bit.
    function automatic int len_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/vq_pingpong_bank_ram_if.sv
// Writer/reader bus for the ping-pong bank buffer.
// master = producer/consumer side, slave = buffer side.
interface vq_pingpong_bank_ram_if
    import vq_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 14,
    parameter int NUM_BANKS  = 2
);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int LEN_W  = len_w(ADDR_WIDTH);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_commit;
    logic                  wr_ready;
    logic [BANK_W-1:0]     wr_bank;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_release;
    logic                  rd_avail;
    logic [BANK_W-1:0]     rd_bank;
    logic [LEN_W-1:0]      rd_len;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        input  wr_ready, wr_bank, rd_avail, rd_bank, rd_len, rd_data, rd_valid, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        output wr_ready, wr_bank, rd_avail, rd_bank, rd_len, rd_data, rd_valid, err
    );

endinterface

// File: rtl/vq_sdp_ram.sv
// Single-clock simple dual-port array with registered read.
// Latency 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1); no backpressure, every re yields one rvalid.
module vq_sdp_ram #(
    parameter int AW         = 13,
    parameter int DW         = 14,
    parameter int DEPTH      = 8192,
    parameter int OUTPUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1;
    logic          v1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= re;
            if (re) begin
                q1 <= mem[raddr];
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DW-1:0] q2;
            logic          v2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        q2 <= q1;
                    end
                end
            end
            assign rdata  = q2;
            assign rvalid = v2;
        end else begin : g_noreg
            assign rdata  = q1;
            assign rvalid = v1;
        end
    endgenerate

endmodule

// File: rtl/vq_pingpong_bank_ram.sv
// Multi-bank ping-pong frame buffer: writer fills bank wp, reader drains committed banks from rp.
// Read latency 1 or 2 (OUTPUT_REG); writer stalls when all banks are committed, reader when none are.
module vq_pingpong_bank_ram
    import vq_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 14,
    parameter int NUM_BANKS  = 2,
    parameter int OUTPUT_REG = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    vq_pingpong_bank_ram_if.slave   bus
);
    localparam int BW    = bank_w(NUM_BANKS);
    localparam int LW    = len_w(ADDR_WIDTH);
    localparam int RAW   = BW + ADDR_WIDTH;
    localparam int DEPTH = NUM_BANKS * (2 ** ADDR_WIDTH);

    localparam logic [2:0]    NB     = 3'(NUM_BANKS);
    localparam logic [BW-1:0] LAST   = BW'(NUM_BANKS - 1);
    localparam logic [LW-1:0] MAXLEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [BW-1:0] wp, rp;
    logic [2:0]    cnt;
    logic [LW-1:0] wr_len, wr_len_nxt;
    logic [LW-1:0] len [NUM_BANKS];
    logic          err_q;
    logic          wr_ok, rd_ok;
    logic          wr_acc, cm_acc, rl_acc, rd_acc, err_req;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_ok  = (cnt < NB);
    assign rd_ok  = (cnt != 3'd0);
    assign wr_acc = bus.wr_en      & wr_ok;
    assign cm_acc = bus.wr_commit  & wr_ok;
    assign rl_acc = bus.rd_release & rd_ok;
    assign rd_acc = bus.rd_en      & rd_ok;

    assign err_req = ((bus.wr_en | bus.wr_commit) & ~wr_ok)
                   | ((bus.rd_en | bus.rd_release) & ~rd_ok);

    // Counts accepted writes, including rewrites, and saturates at a full bank.
    assign wr_len_nxt = (wr_acc && wr_len != MAXLEN) ? wr_len + 1'b1 : wr_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            wr_len <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                len[i] <= '0;
            end
        end else begin
            err_q <= err_req;
            if (cm_acc) begin
                len[wp] <= wr_len_nxt;
                wp      <= ptr_inc(wp);
                wr_len  <= '0;
            end else begin
                wr_len  <= wr_len_nxt;
            end
            if (rl_acc) begin
                rp <= ptr_inc(rp);
            end
            case ({cm_acc, rl_acc})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.wr_ready = wr_ok;
    assign bus.rd_avail = rd_ok;
    assign bus.wr_bank  = wp;
    assign bus.rd_bank  = rp;
    assign bus.rd_len   = len[rp];
    assign bus.err      = err_q;

    // Writer and reader banks differ whenever both are accepted, so no collision handling.
    vq_sdp_ram #(
        .AW         (RAW),
        .DW         (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_acc),
        .waddr  ({wp, bus.wr_addr}),
        .wdata  (bus.wr_data),
        .re     (rd_acc),
        .raddr  ({rp, bus.rd_addr}),
        .rdata  (bus.rd_data),
        .rvalid (bus.rd_valid)
    );

endmodule
